uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Downstream stage of the debug/watchdog frame generator. Accepts bytes on a valid/ready byte interface, buffers them in a small synchronous FIFO and serialises them as 8N1 UART frames on o_tx. The FIFO is needed because the frame generator emits back-to-back bytes, one per clock, while a UART frame takes roughly 10×CLKS_PER_BIT clocks.

Parameters:
- CLKS_PER_BIT, 868, clocks per UART bit (100 MHz / 115200); legal range ≥ 2.
- DEPTH, 16, FIFO entries; must be a power of 2, ≥ 2.
- AW, $clog2(DEPTH), FIFO pointer width (derived; not to be overridden).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_wdata  in  8  byte to transmit.
- i_wvalid  in  1  i_wdata valid this cycle.
- o_wready  out  1  FIFO not full; a write is accepted when i_wvalid & o_wready.
- o_tx  out  1  UART serial line, idle high.
- o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- o_overflow  out  1  sticky: a write arrived while full.
- o_level  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_tx=1, o_wready=1, o_busy=0, o_overflow=0, o_level=0.
  - Pointers are cleared and the FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately; o_tx returns high the next cycle and FIFO contents are discarded.
- FIFO write: on i_wvalid & ~full, store i_wdata. o_level updates the next cycle.
- Write when full: the byte is dropped and o_overflow is set the next cycle. o_overflow stays set until reset.
- "full" is the registered level == DEPTH. A write in the same cycle as a pop while full is still dropped (no same-cycle forwarding).
- FIFO pop: only by the FSM, only when level != 0. Simultaneous push and pop leaves the level unchanged.
- There is no empty bypass: a byte must be resident one cycle before it is popped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If level != 0, pop the head into the shift register, clear the baud counter and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit index 7 completes, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles.
    - On the last STOP cycle, if level != 0, pop and go straight to START (no idle gap between frames).
    - Otherwise go to IDLE.
- Latency: a byte written at cycle N into an empty FIFO is popped at N+1, and o_tx falls at N+2.
- Frame length: exactly 10×CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; bit transitions occur on the wrap. Width is $clog2(CLKS_PER_BIT).
- Pointers are AW bits and wrap modulo DEPTH. Level is AW+1 bits, so 0..DEPTH is representable.
- o_busy = (state != IDLE) | (level != 0), registered.
- o_tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11×CLKS_PER_BIT cycles.
- Undefined: 8N1 as above; no PARITY state or parity logic is synthesised.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - line levels UART_IDLE_LVL=1, UART_START_LVL=0, UART_STOP_LVL=1;
  - default CLKS_PER_BIT.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) with ports push, pop, din, dout, full, empty, level.
- The top level keeps the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Single byte 0x68 written at cycle 10, CLKS_PER_BIT=4:
  - o_tx falls at cycle 12.
  - Line shows bits 0,0,0,1,0,1,1,0 LSB-first, then high.
  - o_busy drops at cycle 52.
- Back-to-back writes 0x68, 0x65, 0xA5 on consecutive cycles (frame-generator pattern):
  - Three contiguous frames with no idle gap.
  - o_level peaks at 2.
  - o_overflow stays 0.
- DEPTH=4, 6 consecutive writes while the first frame is in progress:
  - Writes 1–5 are accepted (one pops early); write 6 is dropped with o_wready=0.
  - o_overflow=1 and remains 1 after the FIFO drains.
- Assert i_rst_n=0 for one cycle mid-DATA of the second of three queued bytes:
  - Next cycle: o_tx=1, o_level=0, o_busy=0, o_overflow=0.
  - No further frames are emitted.
- With UART_TX_PARITY_EN, write 0x07:
  - Parity bit = 1; frame is 11×CLKS_PER_BIT cycles.
- With UART_TX_PARITY_EN, write 0x03:
  - Parity bit = 0.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter.
// State encodings, line levels and the default bit period.
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    localparam int UART_CLKS_PER_BIT = 868;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (!do_push && do_pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to add an even parity bit before the stop bit.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int  CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int  DEPTH        = 16,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_wdata,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_overflow,
    output logic [AW:0] o_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    state_t        state, state_n;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          pop;
    logic          wrap;
    logic [7:0]    dout;
    logic          full;
    logic          empty;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_wvalid),
        .pop   (pop),
        .din   (i_wdata),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );

    assign o_wready = ~full;
    assign wrap     = (baud == BAUD_MAX);

    always_comb begin
        state_n = state;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;
        tx_n    = UART_IDLE_LVL;
        baud_n  = (state == ST_IDLE || wrap) ? '0 : baud + 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = dout;
                    state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = even_parity(dout);
`endif
                end
            end
            ST_START: begin
                tx_n = UART_START_LVL;
                if (wrap) begin
                    state_n = ST_DATA;
                    bit_n   = 3'd0;
                end
            end
            ST_DATA: begin
                tx_n = shift[0];
                if (wrap) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_n = par;
                if (wrap)
                    state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                tx_n = UART_STOP_LVL;
                // Chain straight into the next frame when a byte is waiting.
                if (wrap) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = dout;
                        state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                        par_n   = even_parity(dout);
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            baud       <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            o_tx       <= UART_IDLE_LVL;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            baud       <= baud_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            o_tx       <= tx_n;
            o_busy     <= (state != ST_IDLE) | (o_level != '0);
            o_overflow <= o_overflow | (i_wvalid & full);
`ifdef UART_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end

endmodule
